jk_cmd_conditioner: RTL and testbench
=====================================

Name: jk_cmd_conditioner

Overview:
- Upstream stage of the JK flip-flop (`FF_jk`).
- Conditions three raw, asynchronous, bouncing push-button inputs (set, clear, toggle) into clean one-cycle J/K command pulses.
- j/k outputs connect directly to the flip-flop's j/k inputs; both blocks share the same clock.
- Per channel: two-flop synchronizer, debounce counter, rising-edge detector. A shared priority encoder drives j/k.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clocks a synchronized input must hold a new level before the debounced state changes (board build uses 50000).
- CNT_W, 16, width of the debounce and repeat counters. Must hold DEBOUNCE_CYCLES and REPEAT_CYCLES.
- REPEAT_CYCLES, 8, auto-repeat period in clocks. Used only with JK_REPEAT_EN.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clock edge.
- btn_set  input  1  raw set button, active-high, asynchronous.
- btn_clr  input  1  raw clear button, active-high, asynchronous.
- btn_tgl  input  1  raw toggle button, active-high, asynchronous.
- j  output  1  J command to `FF_jk`; registered.
- k  output  1  K command to `FF_jk`; registered.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset: clears sync flops, debounce counters, debounced states, edge-history flops and the repeat counter. j=0, k=0 on the edge reset is sampled and while it is held.
- Synchronizer: sync1 <= raw; sync2 <= sync1.
- Debounce, per channel (stable, cnt):
  - sync2 == stable: cnt <= 0.
  - Otherwise cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 and sync2 != stable: stable <= sync2 and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles clears cnt and never changes stable.
- Request: req = stable & ~stable_q, where stable_q is stable delayed one clock. Rising edge only; release emits nothing.
- Priority: clr > set > tgl. Lower-priority requests in the same cycle are dropped, not queued.
- Output register, updated each edge:
  - clr request: j=0, k=1.
  - Else set request: j=1, k=0.
  - Else tgl request: j=1, k=1.
  - Else j=0, k=0.
  - Any nonzero j/k lasts exactly one cycle.
- Latency: raw first sampled high at edge 0 and held. stable rises at edge DEBOUNCE_CYCLES+1. j/k valid in the cycle after edge DEBOUNCE_CYCLES+2 (edge 6 with default).
- Held button: one pulse per press.
- Reset mid-operation: any in-progress debounce is aborted. If a button is still held when reset drops, it is re-detected as a new press with full latency counted from the first non-reset edge.
- Counters saturate nowhere and wrap nowhere: their reload rules prevent overflow.

Optional Feature:
- Macro: JK_REPEAT_EN.
- Defined:
  - Repeat counter clears whenever a tgl command (j=k=1) is issued, and whenever tgl stable is 0.
  - Counter increments while tgl stable is 1.
  - On reaching REPEAT_CYCLES-1, a new tgl request is raised, so pulses are REPEAT_CYCLES edges apart.
  - Repeats obey the same priority. A repeat suppressed by clr/set is dropped, and the counter still clears.
  - set/clr never repeat.
- Not defined: no repeat logic. Exactly one tgl pulse per debounced press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8; edge 0 = first edge sampling raw high):
- Reset high 2 cycles, all buttons low 20 cycles -> j=0, k=0 throughout.
- btn_set high from edge 0 for 20 cycles, then low 20 cycles -> j=1, k=0 only in the cycle after edge 6; no pulse on release.
- btn_tgl high for edges 0-2 only (3 cycles) -> j=k=0 throughout (glitch rejected); tgl cnt returns to 0.
- btn_set and btn_clr rise together at edge 0, held 20 cycles -> single j=0, k=1 after edge 6; no later set pulse.
- btn_set high from edge 0 and held; reset high on edges 3-4 -> no pulse near edge 6; j=1, k=0 only after edge 11.
- btn_tgl high on edges 0-37, low from edge 38:
  - With JK_REPEAT_EN: j=k=1 single cycles after edges 6, 14, 22, 30, 38 (five pulses).
  - Without JK_REPEAT_EN: one pulse after edge 6 only.

Source files
------------

// File: rtl/jk_cmd_conditioner.sv
// rtl/jk_cmd_conditioner.sv - push-button to J/K command pulse conditioner
//
// Purpose: turns three raw, bouncing, asynchronous buttons (set, clear, toggle)
// into clean single-cycle J/K commands for the downstream JK flip-flop.
// Each channel: two-flop synchronizer -> debounce counter -> rising-edge
// detector. A shared priority encoder (clr > set > tgl) drives registered j/k.
//
// Optional feature macro: JK_REPEAT_EN (auto-repeat of toggle while held).
//
// Ports:
//   clock   in   single clock, rising edge
//   reset   in   synchronous, active-high
//   btn_set in   raw set button (async, active-high)
//   btn_clr in   raw clear button (async, active-high)
//   btn_tgl in   raw toggle button (async, active-high)
//   j       out  registered J command, one-cycle pulses
//   k       out  registered K command, one-cycle pulses

module jk_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_clr,
  input  logic btn_tgl,
  output logic j,
  output logic k
);

  // Channel indices within the per-channel vectors.
  localparam int CH_SET = 0;
  localparam int CH_CLR = 1;
  localparam int CH_TGL = 2;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Both counters only ever reach (cycles - 1); refuse a width that cannot hold it.
  localparam int MAX_CYC = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  generate
    if (((MAX_CYC - 1) >> CNT_W) != 0) begin : g_cnt_w_too_small
      $error("CNT_W too narrow for DEBOUNCE_CYCLES/REPEAT_CYCLES");
    end
  endgenerate

  logic [2:0]            raw;
  logic [2:0]            sync1_q, sync1_d;
  logic [2:0]            sync2_q, sync2_d;
  logic [2:0]            stable_q, stable_d;
  logic [2:0]            stable_dly_q, stable_dly_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  j_q, j_d;
  logic                  k_q, k_d;
  logic [2:0]            req;
  logic                  tgl_req;
  logic                  rpt_hit;

  assign raw = {btn_tgl, btn_clr, btn_set};

  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = '0;

    for (int i = 0; i < 3; i++) begin
      // Counter only runs while the synchronized level disagrees with the
      // debounced state; any agreement (glitch ending) restarts it from zero.
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    // Press (rising edge of debounced level) only; release emits nothing.
    req     = stable_q & ~stable_dly_q;
    tgl_req = req[CH_TGL] | rpt_hit;

    j_d = 1'b0;
    k_d = 1'b0;
    if (req[CH_CLR]) begin
      k_d = 1'b1;
    end else if (req[CH_SET]) begin
      j_d = 1'b1;
    end else if (tgl_req) begin
      j_d = 1'b1;
      k_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      cnt_q        <= '0;
      j_q          <= 1'b0;
      k_q          <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      j_q          <= j_d;
      k_q          <= k_d;
    end
  end

`ifdef JK_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rpt_q, rpt_d;

  // Restarts on every toggle request (edge or repeat), even when that request
  // loses to clr/set, so a suppressed repeat is simply dropped.
  always_comb begin
    rpt_hit = stable_q[CH_TGL] && (rpt_q == RPT_LAST);
    rpt_d   = '0;
    if (stable_q[CH_TGL] && !tgl_req) begin
      rpt_d = rpt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif

  assign j = j_q;
  assign k = k_q;

endmodule

// File: tb/tb_jk_cmd_conditioner.sv
// tb/tb_jk_cmd_conditioner.sv - scoreboard bench for jk_cmd_conditioner

module tb_jk_cmd_conditioner;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic btn_set = 1'b0;
  logic btn_clr = 1'b0;
  logic btn_tgl = 1'b0;
  logic j;
  logic k;

  typedef struct {
    int         at_edge;
    logic [1:0] jk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   base;

  jk_cmd_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16),
    .REPEAT_CYCLES(8)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .btn_set(btn_set),
    .btn_clr(btn_clr),
    .btn_tgl(btn_tgl),
    .j      (j),
    .k      (k)
  );

  always #5 clock = ~clock;

  // cyc = number of rising edges so far; edge index of the last edge is cyc-1.
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: any nonzero j/k is an output event and must match the queue head.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (j || k) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse edge=%0d jk=%b required no pulse", cyc - 1, {j, k});
      end else begin
        e = exp_q.pop_front();
        if (e.at_edge != cyc - 1 || e.jk != {j, k}) begin
          errors++;
          $display("FAIL pulse edge=%0d jk=%b required edge=%0d jk=%b",
                   cyc - 1, {j, k}, e.at_edge, e.jk);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_pulse(input int at_edge, input logic [1:0] jk);
    exp_t e;
    e.at_edge = at_edge;
    e.jk      = jk;
    exp_q.push_back(e);
  endtask

  task automatic end_test(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_pulses=%0d required 0 (next edge=%0d)",
               name, exp_q.size(), exp_q[0].at_edge);
      exp_q.delete();
    end
  endtask

  initial begin
    // Reset for 2 edges; outputs must be 0 while held.
    step(1);
    checks++;
    if (j !== 1'b0) begin errors++; $display("FAIL reset_j got=%b required 0", j); end
    checks++;
    if (k !== 1'b0) begin errors++; $display("FAIL reset_k got=%b required 0", k); end
    step(1);
    reset = 1'b0;

    // Idle: nothing.
    step(20);
    end_test("idle");

    // Set press, held then released: single 10 after edge 6.
    base = cyc; btn_set = 1'b1;
    expect_pulse(base + 6, 2'b10);
    step(20); btn_set = 1'b0;
    step(20);
    end_test("set_press");

    // Toggle glitch for 3 edges: rejected.
    base = cyc; btn_tgl = 1'b1;
    step(3); btn_tgl = 1'b0;
    step(20);
    end_test("tgl_glitch");

    // Clear alone: single 01.
    base = cyc; btn_clr = 1'b1;
    expect_pulse(base + 6, 2'b01);
    step(10); btn_clr = 1'b0;
    step(20);
    end_test("clr_press");

    // Set and clear together: clear wins, set is dropped.
    base = cyc; btn_set = 1'b1; btn_clr = 1'b1;
    expect_pulse(base + 6, 2'b01);
    step(20); btn_set = 1'b0; btn_clr = 1'b0;
    step(20);
    end_test("set_clr_prio");

    // Set and toggle together: set wins; repeat may still fire later.
    base = cyc; btn_set = 1'b1; btn_tgl = 1'b1;
    expect_pulse(base + 6, 2'b10);
`ifdef JK_REPEAT_EN
    expect_pulse(base + 14, 2'b11);
    expect_pulse(base + 22, 2'b11);
`endif
    step(20); btn_set = 1'b0; btn_tgl = 1'b0;
    step(20);
    end_test("set_tgl_prio");

    // Reset on edges 3-4 while set held: re-detected, pulse after edge 11.
    base = cyc; btn_set = 1'b1;
    expect_pulse(base + 11, 2'b10);
    step(3); reset = 1'b1;
    step(2); reset = 1'b0;
    step(15); btn_set = 1'b0;
    step(20);
    end_test("reset_mid");

    // Toggle held for edges 0-37.
    base = cyc; btn_tgl = 1'b1;
    expect_pulse(base + 6, 2'b11);
`ifdef JK_REPEAT_EN
    expect_pulse(base + 14, 2'b11);
    expect_pulse(base + 22, 2'b11);
    expect_pulse(base + 30, 2'b11);
    expect_pulse(base + 38, 2'b11);
`endif
    step(38); btn_tgl = 1'b0;
    step(20);
    end_test("tgl_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
